// File: rtl/local_sp_stream_reader.sv
// local_sp_stream_reader
// Read-side initiator for a single-port URAM scratchpad. A burst command
// (start address, length) becomes a run of sequential reads. Read tags track
// the fixed memory latency, and returned words land in a small show-ahead FIFO
// that drives a valid/ready stream with a last flag.
module local_sp_stream_reader #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 11,
  parameter int ADDR_RANGE   = 2048,
  parameter int LEN_WIDTH    = 12,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LATENCY + 1);

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [LEN_WIDTH-1:0]    remaining;
  logic                    zero_done;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_last;
  logic [INF_W-1:0]        inflight;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    cmd_fire;
  logic                    credit_ok;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    drain_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read may only be issued when every word already in flight or buffered
  // still has a FIFO slot, so returning data can never overflow the buffer.
  assign cmd_ready    = (state == S_IDLE);
  assign cmd_fire     = cmd_valid & cmd_ready;
  assign credit_ok    = (32'(inflight) + 32'(count)) < FIFO_DEPTH;
  assign issue        = (state == S_ISSUE) && credit_ok;
  assign addr_next    = (addr_q == ADDR_WIDTH'(ADDR_RANGE - 1)) ? '0 : addr_q + 1'b1;
  assign mem_ce0      = issue;
  assign mem_address0 = addr_q;
  assign mem_we0      = 1'b0;
  assign mem_d0       = '0;
  assign push         = tag_valid[READ_LATENCY-1];
  assign out_valid    = (count != '0);
  assign pop          = out_valid & out_ready;
  assign out_data     = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last     = out_valid & fifo_last[rd_ptr];
  assign drain_done   = (state == S_DRAIN) && (inflight == '0) && (count == '0);
  assign done         = zero_done | drain_done;
  assign busy         = (state != S_IDLE) && !drain_done;

  // Burst control: accept a command, walk the address range, then wait for drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      remaining <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= cmd_fire && (cmd_len == '0);
      case (state)
        S_IDLE: begin
          if (cmd_fire && (cmd_len != '0)) begin
            addr_q    <= cmd_addr;
            remaining <= cmd_len;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_q    <= addr_next;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read tags ride alongside the memory pipeline and mark when q0 is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_last[0]  <= (remaining == LEN_WIDTH'(1));
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // Count of reads issued whose data has not yet reached the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO storage captures q0 and its last flag as each tag retires
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_q0;
      fifo_last[wr_ptr] <= tag_last[READ_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO would mean the credit rule is broken
  always @(posedge clk) begin
    assert (!(push && !pop && (count == CNT_W'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_local_sp_stream_reader.sv
// tb_local_sp_stream_reader
// Directed bench for the scratchpad stream reader with a two-stage memory
// model holding mem[i] = i.
module tb_local_sp_stream_reader;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int LW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_d0;
  logic [DW-1:0] mem_q0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic          busy;

  local_sp_stream_reader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0),
    .mem_q0(mem_q0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: two-cycle read latency, word i holds value i
  logic [DW-1:0] mem_p1;
  always @(posedge clk) begin
    if (mem_ce0) mem_p1 <= DW'(mem_address0);
    mem_q0 <= mem_p1;
  end

  int passed = 0;
  int total  = 0;

  int            iss_cyc[$];
  logic [AW-1:0] iss_addr[$];
  int            pop_cyc[$];
  logic [DW-1:0] pop_data[$];
  logic          pop_last[$];
  logic          busyq[$];
  int done_cycle, done_cnt, stall_err, max_out, crdy_busy_hi, crdy_lo, valid_cnt;

  // Issue one command and record everything the DUT does until the cycle after done
  task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input bit toggle, input bit hold, input int budget);
    logic pstall;
    logic [DW-1:0] pd;
    logic pl;
    int outstanding;
    iss_cyc.delete(); iss_addr.delete(); pop_cyc.delete();
    pop_data.delete(); pop_last.delete(); busyq.delete();
    done_cycle = -1; done_cnt = 0; stall_err = 0; max_out = 0;
    crdy_busy_hi = 0; crdy_lo = 0; valid_cnt = 0;
    pstall = 1'b0; pd = '0; pl = 1'b0;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      out_ready = toggle ? (cyc % 4 == 0) : 1'b1;
      if (pstall && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) stall_err++;
      pstall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (cmd_ready !== 1'b1) crdy_lo++;
      if (cyc >= 1 && done_cycle < 0 && cmd_ready === 1'b1) crdy_busy_hi++;
      if (mem_ce0 === 1'b1) begin
        iss_cyc.push_back(cyc);
        iss_addr.push_back(mem_address0);
      end
      if (out_valid === 1'b1) valid_cnt++;
      if (out_valid === 1'b1 && out_ready) begin
        pop_cyc.push_back(cyc);
        pop_data.push_back(out_data);
        pop_last.push_back(out_last);
      end
      outstanding = iss_addr.size() - pop_data.size();
      if (outstanding > max_out) max_out = outstanding;
      busyq.push_back(busy);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc == done_cycle + 1) break;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    else passed++;
    total++;
    if ({mem_ce0, mem_we0, out_valid, out_last, done, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {mem_ce0, mem_we0, out_valid, out_last, done, busy});
    else passed++;
    total++;
    if (mem_address0 !== '0 || out_data !== '0 || mem_d0 !== '0)
      $display("FAIL reset_buses: got addr %0d data %0h d0 %0h expected 0", mem_address0, out_data, mem_d0);
    else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_cmd(11'd5, 12'd4, 1'b0, 1'b0, 40);
    total++;
    if (done_cycle !== 8 || done_cnt !== 1)
      $display("FAIL basic_done: got cycle %0d count %0d expected cycle 8 count 1", done_cycle, done_cnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= iss_addr.size() || iss_cyc[i] !== i + 1 || iss_addr[i] !== AW'(5 + i))
        $display("FAIL basic_issue%0d: got cycle %0d addr %0d expected cycle %0d addr %0d",
                 i, iss_cyc[i], iss_addr[i], i + 1, 5 + i);
      else passed++;
      total++;
      if (i >= pop_data.size() || pop_cyc[i] !== i + 4 || pop_data[i] !== DW'(5 + i) || pop_last[i] !== (i == 3))
        $display("FAIL basic_word%0d: got cycle %0d data %0d last %b expected cycle %0d data %0d last %b",
                 i, pop_cyc[i], pop_data[i], pop_last[i], i + 4, 5 + i, (i == 3));
      else passed++;
    end
    total++;
    if (iss_addr.size() !== 4 || pop_data.size() !== 4)
      $display("FAIL basic_counts: got %0d issues %0d words expected 4 and 4", iss_addr.size(), pop_data.size());
    else passed++;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (c >= busyq.size() || busyq[c] !== (c >= 1 && c < 8))
        $display("FAIL basic_busy%0d: got %b expected %b", c, busyq[c], (c >= 1 && c < 8));
      else passed++;
    end
    total++;
    if (crdy_busy_hi !== 0) $display("FAIL basic_cmd_ready: got %0d busy-ready cycles expected 0", crdy_busy_hi);
    else passed++;
  endtask

  task automatic test_wrap();
    run_cmd(11'd2046, 12'd4, 1'b0, 1'b0, 40);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= pop_data.size() || iss_addr[i] !== AW'((2046 + i) % 2048) ||
          pop_data[i] !== DW'((2046 + i) % 2048) || pop_last[i] !== (i == 3))
        $display("FAIL wrap_word%0d: got addr %0d data %0d last %b expected %0d last %b",
                 i, iss_addr[i], pop_data[i], pop_last[i], (2046 + i) % 2048, (i == 3));
      else passed++;
    end
    total++;
    if (done_cnt !== 1 || pop_data.size() !== 4)
      $display("FAIL wrap_done: got done %0d words %0d expected 1 and 4", done_cnt, pop_data.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    run_cmd(11'd10, 12'd16, 1'b1, 1'b0, 300);
    total++;
    if (pop_data.size() !== 16) $display("FAIL bp_count: got %0d words expected 16", pop_data.size());
    else passed++;
    bad = 0;
    for (int i = 0; i < pop_data.size(); i++)
      if (pop_data[i] !== DW'(10 + i) || pop_last[i] !== (i == 15)) bad++;
    total++;
    if (bad !== 0) $display("FAIL bp_order: got %0d bad words expected 0", bad);
    else passed++;
    total++;
    if (stall_err !== 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err);
    else passed++;
    total++;
    if (max_out > DEPTH) $display("FAIL bp_outstanding: got %0d expected at most %0d", max_out, DEPTH);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL bp_done: got %0d expected 1", done_cnt);
    else passed++;
  endtask

  task automatic test_zero_len();
    run_cmd(11'd7, 12'd0, 1'b0, 1'b0, 20);
    total++;
    if (done_cycle !== 1 || done_cnt !== 1)
      $display("FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_cycle, done_cnt);
    else passed++;
    total++;
    if (iss_addr.size() !== 0 || valid_cnt !== 0)
      $display("FAIL zero_activity: got %0d issues %0d valid cycles expected 0 and 0", iss_addr.size(), valid_cnt);
    else passed++;
    total++;
    if (crdy_lo !== 0) $display("FAIL zero_cmd_ready: got %0d low cycles expected 0", crdy_lo);
    else passed++;
  endtask

  task automatic test_reset_midburst();
    cmd_addr = 11'd40; cmd_len = 12'd8; cmd_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_ce0 !== 1'b1 || mem_address0 !== 11'd42)
      $display("FAIL mid_pre: got ce %b addr %0d expected ce 1 addr 42", mem_ce0, mem_address0);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || {mem_ce0, out_valid, out_last, done, busy} !== 5'b0 || mem_address0 !== '0 || out_data !== '0)
      $display("FAIL mid_reset: got ready %b ctrl %b addr %0d expected ready 1 ctrl 00000 addr 0",
               cmd_ready, {mem_ce0, out_valid, out_last, done, busy}, mem_address0);
    else passed++;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    run_cmd(11'd0, 12'd2, 1'b0, 1'b0, 40);
    total++;
    if (pop_data.size() !== 2 || pop_data[0] !== DW'(0) || pop_data[1] !== DW'(1) || done_cnt !== 1)
      $display("FAIL mid_after: got %0d words first %0d second %0d done %0d expected 2 words 0 1 done 1",
               pop_data.size(), pop_data[0], pop_data[1], done_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_cmd(11'd100, 12'd3, 1'b0, 1'b1, 60);
    total++;
    if (crdy_busy_hi !== 0) $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", crdy_busy_hi);
    else passed++;
    total++;
    if (pop_data.size() !== 3 || pop_data[0] !== DW'(100) || pop_data[2] !== DW'(102))
      $display("FAIL b2b_first: got %0d words first %0d last %0d expected 3 words 100..102",
               pop_data.size(), pop_data[0], pop_data[2]);
    else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after: got %b expected 1", cmd_ready);
    else passed++;
    run_cmd(11'd200, 12'd2, 1'b0, 1'b0, 40);
    total++;
    if (iss_cyc.size() < 1 || iss_cyc[0] !== 1 || pop_data.size() !== 2 ||
        pop_data[0] !== DW'(200) || pop_data[1] !== DW'(201) || done_cnt !== 1)
      $display("FAIL b2b_second: got first issue %0d words %0d data %0d %0d expected issue 1 words 2 data 200 201",
               iss_cyc[0], pop_data.size(), pop_data[0], pop_data[1]);
    else passed++;
  endtask

  // Runs every scenario in order, then reports the tally
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_midburst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Stops a wedged run with a visible failure
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
